// File: rtl/ln_affine_param_loader.sv
`timescale 1ns/1ps
// ln_affine_param_loader
// Loads the LayerNorm affine vectors (gamma, and beta unless in RMSNorm mode) from DRAM into two
// on-chip parameter buffers.
//
// Operation:
//   - A start pulse latches the configuration.
//   - Burst read requests go out on the MCIF read channel, with a bounded number of bursts
//     outstanding.
//   - Returned beats are written, in order, to the gamma buffer and then the beta buffer.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i                 launch pulse (ignored while busy)
//   mode_rms_i              1: gamma only, 0: gamma then beta
//   ch_groups_i             channel count / TOUT
//   wt/bias_base_addr_i     DRAM byte base addresses
//   rd_req_*                burst request channel, pd = {len, base, offset}
//   rd_resp_*               response beat channel
//   rd_fifo_pop_o           response beat accepted
//   busy_o, done_o          status, done is a one-cycle pulse
//   wt/bias_rd_*            1-cycle-latency buffer read ports
module ln_affine_param_loader #(
  parameter int unsigned DW         = 16,
  parameter int unsigned TOUT       = 32,
  parameter int unsigned LOG2_BURST = 4,
  parameter int unsigned LOG2_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_OUT    = 4,
  localparam int unsigned BW        = DW * TOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           mode_rms_i,
  input  logic [LOG2_DEPTH:0]            ch_groups_i,
  input  logic [ADDR_W-1:0]              wt_base_addr_i,
  input  logic [ADDR_W-1:0]              bias_base_addr_i,
  output logic                           rd_req_vld_o,
  input  logic                           rd_req_rdy_i,
  output logic [LOG2_BURST+2*ADDR_W-1:0] rd_req_pd_o,
  input  logic                           rd_resp_vld_i,
  output logic                           rd_resp_rdy_o,
  input  logic [BW-1:0]                  rd_resp_pd_i,
  output logic                           rd_fifo_pop_o,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic                           wt_rd_en_i,
  input  logic                           bias_rd_en_i,
  input  logic [LOG2_DEPTH-1:0]          wt_rd_addr_i,
  input  logic [LOG2_DEPTH-1:0]          bias_rd_addr_i,
  output logic [BW-1:0]                  wt_rd_dat_o,
  output logic [BW-1:0]                  bias_rd_dat_o,
  output logic                           wt_rd_vld_o,
  output logic                           bias_rd_vld_o
);

  localparam int unsigned Burst      = 1 << LOG2_BURST;
  localparam int unsigned Depth      = 1 << LOG2_DEPTH;
  localparam int unsigned CW         = LOG2_DEPTH + 1;
  localparam int unsigned OW         = 4;
  localparam int unsigned BurstBytes = Burst * (BW / 8);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  mode_rms_q;
  logic [CW-1:0]         ch_groups_q;
  logic [ADDR_W-1:0]     wt_base_q, bias_base_q;
  logic [CW-1:0]         k_q, k_d, rb_q, rb_d;
  logic                  t_q, t_d, rt_q, rt_d;
  logic [LOG2_BURST-1:0] b_q, b_d;
  logic [OW-1:0]         out_q, out_d;

  logic                  launch, req_acc, pop;
  logic [CW:0]           nb;
  logic [CW-1:0]         nb_m1;
  logic [LOG2_BURST-1:0] last_len, req_len, resp_len;
  logic                  req_last_burst, resp_last_burst, beat_last, final_beat;
  logic [LOG2_DEPTH-1:0] waddr;

  assign launch = start_i && (state_q == StIdle);

  // Bursts per table; nb_m1 is only consulted when ch_groups_q != 0.
  assign nb    = ({1'b0, ch_groups_q} + (CW+1)'(Burst - 1)) >> LOG2_BURST;
  assign nb_m1 = CW'(nb - (CW+1)'(1));
  // Low bits of (ch_groups-1) give beats-1 of the last burst, including the full-burst case.
  assign last_len = LOG2_BURST'(ch_groups_q - CW'(1));

  assign req_last_burst  = (k_q == nb_m1);
  assign req_len         = req_last_burst ? last_len : LOG2_BURST'(Burst - 1);
  assign resp_last_burst = (rb_q == nb_m1);
  assign resp_len        = resp_last_burst ? last_len : LOG2_BURST'(Burst - 1);

  assign rd_req_vld_o = (state_q == StReq) && (out_q < OW'(MAX_OUT));
  assign req_acc      = rd_req_vld_o && rd_req_rdy_i;
  assign rd_req_pd_o  = rd_req_vld_o ?
                        {req_len, (t_q ? bias_base_q : wt_base_q),
                         ADDR_W'(k_q) * ADDR_W'(BurstBytes)} : '0;

  assign rd_resp_rdy_o = (state_q == StReq) || (state_q == StDrain);
  assign pop           = rd_resp_vld_i && rd_resp_rdy_o;
  assign rd_fifo_pop_o = pop;
  assign beat_last     = (b_q == resp_len);
  assign final_beat    = pop && beat_last && resp_last_burst && (mode_rms_q || rt_q);
  assign waddr         = LOG2_DEPTH'({rb_q, b_q});

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = (ch_groups_i == '0) ? StDone : StReq;
      StReq:   if (req_acc && req_last_burst && (mode_rms_q || t_q)) state_d = StDrain;
      StDrain: if (final_beat) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    k_d   = k_q;
    t_d   = t_q;
    rb_d  = rb_q;
    rt_d  = rt_q;
    b_d   = b_q;
    out_d = out_q;
    if (launch) begin
      k_d   = '0;
      t_d   = 1'b0;
      rb_d  = '0;
      rt_d  = 1'b0;
      b_d   = '0;
      out_d = '0;
    end else begin
      if (req_acc) begin
        if (req_last_burst) begin
          k_d = '0;
          t_d = 1'b1;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      if (pop) begin
        if (beat_last) begin
          b_d = '0;
          if (resp_last_burst) begin
            rb_d = '0;
            rt_d = 1'b1;
          end else begin
            rb_d = rb_q + CW'(1);
          end
        end else begin
          b_d = b_q + LOG2_BURST'(1);
        end
      end
      // A request accepted alongside a burst's last beat leaves the count unchanged.
      if (req_acc && !(pop && beat_last)) out_d = out_q + OW'(1);
      else if (!req_acc && pop && beat_last) out_d = out_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_rms_q  <= 1'b0;
      ch_groups_q <= '0;
      wt_base_q   <= '0;
      bias_base_q <= '0;
      k_q         <= '0;
      t_q         <= 1'b0;
      rb_q        <= '0;
      rt_q        <= 1'b0;
      b_q         <= '0;
      out_q       <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      rb_q    <= rb_d;
      rt_q    <= rt_d;
      b_q     <= b_d;
      out_q   <= out_d;
      if (launch) begin
        mode_rms_q  <= mode_rms_i;
        ch_groups_q <= ch_groups_i;
        wt_base_q   <= wt_base_addr_i;
        bias_base_q <= bias_base_addr_i;
      end
    end
  end

  // Parameter buffers: contents are not reset.
  logic [BW-1:0] wt_mem   [Depth];
  logic [BW-1:0] bias_mem [Depth];

  always_ff @(posedge clk) begin
    if (pop && !rt_q) wt_mem[waddr]   <= rd_resp_pd_i;
    if (pop && rt_q)  bias_mem[waddr] <= rd_resp_pd_i;
  end

  // Registered reads; a same-cycle write to the same address is seen on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_rd_dat_o   <= '0;
      bias_rd_dat_o <= '0;
      wt_rd_vld_o   <= 1'b0;
      bias_rd_vld_o <= 1'b0;
    end else begin
      wt_rd_vld_o   <= wt_rd_en_i;
      bias_rd_vld_o <= bias_rd_en_i;
      if (wt_rd_en_i)   wt_rd_dat_o   <= wt_mem[wt_rd_addr_i];
      if (bias_rd_en_i) bias_rd_dat_o <= bias_mem[bias_rd_addr_i];
    end
  end

endmodule

// File: doc/ln_affine_param_loader.md
Name: ln_affine_param_loader

Overview:
Parametrised successor to the LayerNorm stage-0 parameter loader. On start, it DMA-reads the per-channel affine vectors (gamma, and beta unless in RMSNorm mode) from independent DRAM base addresses through the MCIF read channel. Read requests are issued in AXI bursts with a bounded number of outstanding bursts. Returned beats are written into two on-chip parameter buffers, which the LN datapath reads through 1-cycle-latency ports.

Parameters:
DW, 16, bits per element
TOUT, 32, elements per beat; beat width BW=DW*TOUT
LOG2_BURST, 4, log2 of max beats per burst (BURST=16)
LOG2_DEPTH, 8, log2 of buffer depth in beats (max channels = TOUT<<LOG2_DEPTH)
ADDR_W, 32, DRAM address width
MAX_OUT, 4, max outstanding bursts (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle launch pulse, ignored while busy
mode_rms  in  1  1=load gamma only; 0=gamma then beta
ch_groups  in  LOG2_DEPTH+1  channel count / TOUT, valid range 0..2^LOG2_DEPTH
wt_base_addr  in  ADDR_W  gamma base byte address
bias_base_addr  in  ADDR_W  beta base byte address
rd_req_vld  out  1  burst request valid
rd_req_rdy  in  1  MCIF accepts request
rd_req_pd  out  LOG2_BURST+2*ADDR_W  {len, base, offset}
rd_resp_vld  in  1  response beat valid
rd_resp_rdy  out  1  loader accepts beat
rd_resp_pd  in  BW  response beat
rd_fifo_pop  out  1  equals rd_resp_vld&rd_resp_rdy
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
wt_rd_en, bias_rd_en  in  1  buffer read strobes
wt_rd_addr, bias_rd_addr  in  LOG2_DEPTH  beat addresses
wt_rd_dat, bias_rd_dat  out  BW  read data
wt_rd_vld, bias_rd_vld  out  1  read data valid

Behaviour:
- Reset values: all outputs and counters are 0, busy=0, and the state is IDLE. Buffer contents are undefined after reset.
- Reset asserted mid-operation aborts immediately; no done pulse is generated.
- Latched at start: mode_rms, ch_groups, and both base addresses. Input changes while busy have no effect.
- Derived values:
  - NT (tables) = mode_rms ? 1 : 2.
  - NB (bursts per table) = ceil(ch_groups/BURST).
  - Last-burst beats = ch_groups mod BURST, or BURST if that is 0.
- Request-side FSM: IDLE -> REQ on start with ch_groups!=0. REQ -> DRAIN when the final request is accepted.
- Response-side FSM: DRAIN -> DONE when the final beat of the last table is written. DONE -> IDLE after 1 cycle, with done=1 during DONE.
- start with ch_groups==0: go directly to DONE, so done pulses the cycle after start. No requests are issued.
- busy=1 in REQ, DRAIN and DONE.
- Request counters: burst index k (0..NB-1) and table t (0..NT-1). Both advance on rd_req_vld&rd_req_rdy; k wraps to 0 and t increments.
- Request fields:
  - len = beats-1, so BURST-1 for non-last bursts.
  - base = (t==0) ? wt_base_addr : bias_base_addr.
  - offset = k * BURST * BW/8, truncated to ADDR_W.
- rd_req_vld=1 in REQ while outstanding<MAX_OUT. rd_req_pd is held stable while vld=1 and rdy=0.
- Outstanding counter:
  - +1 on request accept; -1 on the accepted last beat of a burst.
  - Simultaneous accept and last beat leaves the count unchanged.
  - Must never exceed MAX_OUT or underflow.
- rd_resp_rdy = busy and not DONE.
- Response counters: beat b (0..current len), burst index rb, table rt. They mirror the request order because MCIF returns responses in order.
- Write address = rb*BURST + b. The beat is written to the gamma buffer when rt==0, otherwise to the beta buffer.
- In RMS mode the beta buffer is never written and keeps its prior contents.
- Buffers: simple dual-port, DEPTH=2^LOG2_DEPTH, BW wide.
  - Read: rd_dat and rd_vld are registered 1 cycle after rd_en.
  - Same-cycle read and write to the same address returns the old data.
  - Reads are permitted at any time, including while busy.
- rd_fifo_pop = rd_resp_vld & rd_resp_rdy.

Test Plan:
- LN mode, ch_groups=40, wt_base=0x1000, bias_base=0x8000, rdy=1, resp immediate -> 6 requests:
  - lens 15,15,7 with offsets 0x0,0x400,0x800 on base 0x1000, then the same on base 0x8000.
  - 80 pops; gamma written at addresses 0..39, beta at 0..39; done pulses 1 cycle after the 80th beat.
- RMS mode, ch_groups=32 -> 2 requests, both len 15 (offsets 0x0,0x400). Beta buffer is unchanged, checked via readback of preloaded values.
- MAX_OUT=4, ch_groups=256, rdy=1, responses withheld -> rd_req_vld drops after 4 accepts. Releasing one full burst re-raises vld exactly once.
- ch_groups=0 -> no rd_req_vld, done one cycle after start, busy high for that cycle only. A second start while busy is ignored: request count is unchanged.
- Random rd_req_rdy/rd_resp_vld backpressure with ch_groups=1 -> single len-0 request per table. Readback of addr 0 gives wt_rd_vld one cycle after rd_en, with data equal to the DRAM word.
- Assert rst_n low after 3 of 6 beats -> all outputs 0 immediately, no done. A new start then completes normally.
